// File: rtl/morse_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// morse_stream_decoder_if
//   Bundles the symbol inputs and the character FIFO handshake of the Morse
//   decoder. The key-timing front end and the character consumer sit on the
//   master side. The decoder sits on the slave side.
//
//   dot/dash/lg/wg : one symbol or gap event per clock (front end -> decoder)
//   rd_en          : consumer pop request; acts only while dvalid=1
//   dout           : FIFO head character, bit7 always 0
//   dvalid         : FIFO non-empty, dout valid
//   error          : one-cycle error pulse
//   fifo_count     : number of characters held in the FIFO
// -----------------------------------------------------------------------------
interface morse_stream_decoder_if #(
  parameter int CNT_W = 4
);
  logic             dot;
  logic             dash;
  logic             lg;
  logic             wg;
  logic             rd_en;
  logic [7:0]       dout;
  logic             dvalid;
  logic             error;
  logic [CNT_W-1:0] fifo_count;

  modport master (
    output dot, dash, lg, wg, rd_en,
    input  dout, dvalid, error, fifo_count
  );

  modport slave (
    input  dot, dash, lg, wg, rd_en,
    output dout, dvalid, error, fifo_count
  );
endinterface

// File: rtl/morse_stream_decoder.sv
// -----------------------------------------------------------------------------
// morse_stream_decoder
//   Collects dot/dash symbols into letters of up to MAX_LEN symbols. On a letter
//   gap (lg) or a word gap (wg) it translates the letter to 7-bit ASCII: A-Z,
//   0-9 and '='. The character goes into a FIFO_DEPTH-entry output FIFO. A word
//   gap also queues a single space. Unknown codes, symbol overruns, dot+dash
//   collisions and FIFO overflow each raise a one-cycle error pulse.
//
//   Optional feature: define MORSE_PUNCT_EN to also decode . , ? - and /.
//   This needs MAX_LEN >= 6. When it is not defined, those codes are misses.
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : morse_stream_decoder_if slave (symbols in, FIFO handshake out)
// -----------------------------------------------------------------------------
module morse_stream_decoder #(
  parameter int MAX_LEN    = 6,   // 5..8
  parameter int FIFO_DEPTH = 8,   // power of 2, >= 2
  parameter int CNT_W      = 4    // 2**CNT_W > FIFO_DEPTH
) (
  input logic                   clk,
  input logic                   rst_n,
  morse_stream_decoder_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [0:0] IDLE       = 1'b0;
  localparam logic [0:0] EMIT_SPACE = 1'b1;

  // Returns {hit, ascii}. The code is right-aligned, with the first symbol in
  // the most significant used bit. Dot = 0, dash = 1.
  function automatic logic [7:0] lookup(input logic [3:0] len, input logic [7:0] code);
    logic [7:0] r;
    case ({len, code})
      {4'd2, 8'b01}:    r = {1'b1, 7'h41}; // A
      {4'd4, 8'b1000}:  r = {1'b1, 7'h42}; // B
      {4'd4, 8'b1010}:  r = {1'b1, 7'h43}; // C
      {4'd3, 8'b100}:   r = {1'b1, 7'h44}; // D
      {4'd1, 8'b0}:     r = {1'b1, 7'h45}; // E
      {4'd4, 8'b0010}:  r = {1'b1, 7'h46}; // F
      {4'd3, 8'b110}:   r = {1'b1, 7'h47}; // G
      {4'd4, 8'b0000}:  r = {1'b1, 7'h48}; // H
      {4'd2, 8'b00}:    r = {1'b1, 7'h49}; // I
      {4'd4, 8'b0111}:  r = {1'b1, 7'h4A}; // J
      {4'd3, 8'b101}:   r = {1'b1, 7'h4B}; // K
      {4'd4, 8'b0100}:  r = {1'b1, 7'h4C}; // L
      {4'd2, 8'b11}:    r = {1'b1, 7'h4D}; // M
      {4'd2, 8'b10}:    r = {1'b1, 7'h4E}; // N
      {4'd3, 8'b111}:   r = {1'b1, 7'h4F}; // O
      {4'd4, 8'b0110}:  r = {1'b1, 7'h50}; // P
      {4'd4, 8'b1101}:  r = {1'b1, 7'h51}; // Q
      {4'd3, 8'b010}:   r = {1'b1, 7'h52}; // R
      {4'd3, 8'b000}:   r = {1'b1, 7'h53}; // S
      {4'd1, 8'b1}:     r = {1'b1, 7'h54}; // T
      {4'd3, 8'b001}:   r = {1'b1, 7'h55}; // U
      {4'd4, 8'b0001}:  r = {1'b1, 7'h56}; // V
      {4'd3, 8'b011}:   r = {1'b1, 7'h57}; // W
      {4'd4, 8'b1001}:  r = {1'b1, 7'h58}; // X
      {4'd4, 8'b1011}:  r = {1'b1, 7'h59}; // Y
      {4'd4, 8'b1100}:  r = {1'b1, 7'h5A}; // Z
      {4'd5, 8'b11111}: r = {1'b1, 7'h30}; // 0
      {4'd5, 8'b01111}: r = {1'b1, 7'h31}; // 1
      {4'd5, 8'b00111}: r = {1'b1, 7'h32}; // 2
      {4'd5, 8'b00011}: r = {1'b1, 7'h33}; // 3
      {4'd5, 8'b00001}: r = {1'b1, 7'h34}; // 4
      {4'd5, 8'b00000}: r = {1'b1, 7'h35}; // 5
      {4'd5, 8'b10000}: r = {1'b1, 7'h36}; // 6
      {4'd5, 8'b11000}: r = {1'b1, 7'h37}; // 7
      {4'd5, 8'b11100}: r = {1'b1, 7'h38}; // 8
      {4'd5, 8'b11110}: r = {1'b1, 7'h39}; // 9
      {4'd5, 8'b10001}: r = {1'b1, 7'h3D}; // =
`ifdef MORSE_PUNCT_EN
      {4'd6, 8'b010101}: r = {1'b1, 7'h2E}; // .
      {4'd6, 8'b110011}: r = {1'b1, 7'h2C}; // ,
      {4'd6, 8'b001100}: r = {1'b1, 7'h3F}; // ?
      {4'd6, 8'b100001}: r = {1'b1, 7'h2D}; // -
      {4'd5, 8'b10010}:  r = {1'b1, 7'h2F}; // /
`endif
      default:          r = 8'h00;
    endcase
    return r;
  endfunction

  logic [0:0]         state_q, state_n;
  logic [MAX_LEN-1:0] bits_q, bits_n;
  logic [3:0]         len_q, len_n;
  logic               bad_q, bad_n;
  logic               last_space_q;  // suppresses the space: last push was 0x20 or nothing was pushed yet
  logic [7:0]         look;
  logic               push_req;
  logic [6:0]         push_char;
  logic               err_sym, err_miss;

  logic [6:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               err_q;
  logic               pop, full, push_ok, drop;

  // NOTE: every variable gets a default at the top of the block, so an
  // incomplete branch cannot infer a latch.
  always_comb begin
    state_n   = state_q;
    bits_n    = bits_q;
    len_n     = len_q;
    bad_n     = bad_q;
    look      = 8'h00;
    push_req  = 1'b0;
    push_char = 7'h00;
    err_sym   = 1'b0;
    err_miss  = 1'b0;

    // The symbol is appended first, so a gap in the same cycle closes the letter including it.
    if (bus.dot && bus.dash) begin
      err_sym = 1'b1;
    end else if (bus.dot || bus.dash) begin
      if (len_q == 4'(MAX_LEN)) begin
        err_sym = 1'b1;
        bad_n   = 1'b1;
      end else begin
        bits_n = {bits_q[MAX_LEN-2:0], bus.dash};
        len_n  = len_q + 4'd1;
      end
    end

    if (state_q == EMIT_SPACE) begin
      // Gaps are ignored here. The word-gap space is the only push this cycle.
      state_n = IDLE;
      if (!last_space_q) begin
        push_req  = 1'b1;
        push_char = 7'h20;
      end
    end else if (bus.lg || bus.wg) begin
      if (len_n != 4'd0 && !bad_n) begin
        look = lookup(len_n, 8'(bits_n));
        if (look[7]) begin
          push_req  = 1'b1;
          push_char = look[6:0];
        end else begin
          err_miss = 1'b1;
        end
      end
      bits_n = '0;
      len_n  = 4'd0;
      bad_n  = 1'b0;
      if (bus.wg) state_n = EMIT_SPACE;
    end
  end

  assign pop     = bus.dvalid & bus.rd_en;
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign push_ok = push_req & (~full | pop);
  assign drop    = push_req & full & ~pop;

  // NOTE: state registers use non-blocking assignments. Every flop in this
  // block then samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bits_q       <= '0;
      len_q        <= 4'd0;
      bad_q        <= 1'b0;
      last_space_q <= 1'b1;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_n;
      bits_q  <= bits_n;
      len_q   <= len_n;
      bad_q   <= bad_n;
      err_q   <= err_sym | err_miss | drop;
      if (push_ok) begin
        wr_ptr       <= wr_ptr + 1'b1;
        last_space_q <= (push_char == 7'h20);
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset. dout is gated by dvalid, so stale
  // contents are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_char;
  end

  assign bus.dvalid     = (count != '0);
  assign bus.dout       = bus.dvalid ? {1'b0, mem[rd_ptr]} : 8'h00;
  assign bus.error      = err_q;
  assign bus.fifo_count = count;

endmodule
